fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Single-clock, parametrised FIFO; the same-clock successor of the team's dual-clock FIFO. Used wherever producer and consumer share one clock domain. Adds the following, none of which the dual-clock version has:
- fill-level output
- programmable almost-full/almost-empty thresholds
- selectable standard or first-word-fall-through (FWFT) read mode
- sticky overflow/underflow error flags with clear

Parameters:
MEMORY_WIDTH, 8, data word width in bits
ADDRESS_SIZE, 3, log2 of depth; MEMORY_DEPTH = 2**ADDRESS_SIZE (power of two only)
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..MEMORY_DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..MEMORY_DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
w_en  input  1  write request
wdata  input  MEMORY_WIDTH  write data
r_en  input  1  read request
clr_err  input  1  synchronous clear of w_overflow/r_underflow
rdata  output  MEMORY_WIDTH  read data
w_full  output  1  count == MEMORY_DEPTH
r_empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDRESS_SIZE+1  current fill level, 0..MEMORY_DEPTH
w_overflow  output  1  sticky: write attempted while full
r_underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high. While rst=1, regardless of clk:
  - w_ptr = r_ptr = 0, count = 0
  - r_empty = 1, almost_empty = 1, w_full = 0, almost_full = 0
  - rdata = 0, w_overflow = r_underflow = 0
  - Memory contents are not reset.
- Pointers: ADDRESS_SIZE+1 bits, binary; the low ADDRESS_SIZE bits address memory; the MSB is the wrap bit.
  - count = w_ptr - r_ptr, modulo 2**(ADDRESS_SIZE+1).
  - w_full when the pointers differ only in the MSB; r_empty when the pointers are equal.
- Flags are combinational from the registered pointers, so they are valid in the cycle after the edge that changed the pointers. No registered lookahead.
- Accepted write (aw) = w_en & !w_full. On aw: memory[w_ptr[low]] <= wdata; w_ptr++.
- Accepted read (ar) = r_en & !r_empty. On ar: r_ptr++.
- Simultaneous aw and ar: both pointers advance and count is unchanged.
- While full, w_en with r_en: the read is accepted and the write is rejected. Full is evaluated before the read.
- While empty, w_en with r_en: the write is accepted and the read is rejected. r_underflow sets.
- Read data, FWFT=0:
  - rdata is registered: rdata <= memory[r_ptr[low]] on ar, valid the cycle after the ar edge.
  - rdata holds its value when there is no ar.
- Read data, FWFT=1:
  - rdata = memory[r_ptr[low]] combinationally, always presenting the head word while !r_empty.
  - r_en acts as a pop/acknowledge.
  - The first written word appears on rdata one cycle after its write edge, together with r_empty falling.
  - rdata is undefined while r_empty=1.
- Error flags:
  - w_overflow sets on the edge where w_en & w_full.
  - r_underflow sets on the edge where r_en & r_empty.
  - Both hold until clr_err=1 on an edge. If set and clear coincide, set wins.
  - FIFO state is never corrupted by a rejected access.
- Wrap-around: pointers roll over 2*DEPTH-1 -> 0 naturally; count stays correct across the wrap.
- Reset asserted mid-operation: all state returns to reset values immediately. In-flight data is discarded.

Decomposition:
- Shared package fifo_pkg:
  - clog2 helper function
  - ptr/count width localparams derived from ADDRESS_SIZE
  - rd_mode constants FWFT_OFF = 0, FWFT_ON = 1
  - This package is shared with the dual-clock FIFO.
- One sub-module, fifo_sync_ctrl: pointers, count, full/empty/almost flags, error flags; emits w_addr/r_addr and aw/ar.
- The top level holds the memory array and the rdata path (mode-selected by a generate on FWFT).

Test Plan:
1. Reset then idle, WIDTH=8/ADDR=3: count=0, r_empty=1, almost_empty=1, w_full=0, rdata=0x00, error flags 0.
2. Write 0x01..0x08 back-to-back:
   - count ramps 1..8; almost_full rises at count=6; w_full=1 after the 8th write.
   - A 9th write of 0xFF sets w_overflow, leaves count=8 and leaves memory unchanged.
3. FWFT=0, read 8 from full: rdata = 0x01..0x08 each one cycle after r_en; r_empty=1 after the 8th read; a further r_en sets r_underflow; clr_err clears both flags.
4. FWFT=1, single write 0xA5 to empty: the next cycle r_empty=0 and rdata=0xA5 with no r_en; r_en pops it and r_empty=1 the next cycle.
5. Wrap and simultaneous access:
   - Fill to 4, then 20 cycles of w_en=r_en=1 with incrementing data: count stays 4 and read order is preserved across the pointer wrap.
   - While full with w_en=r_en=1: count 8 -> 7, write dropped, w_overflow=1.
6. Assert rst asynchronously mid-burst at count=5: count, flags and rdata return to reset values before the next clk edge; after release, writing 0x3C then reading yields 0x3C.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants and width helpers for single- and dual-clock FIFOs
package fifo_pkg;
  localparam bit FWFT_OFF = 1'b0;
  localparam bit FWFT_ON = 1'b1;
  localparam int DEF_ADDRESS_SIZE = 3;
  localparam int DEF_PTR_W = DEF_ADDRESS_SIZE + 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ptr_w(input int address_size);
    return address_size + 1;
  endfunction
endpackage

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: pointers, fill level, full/empty/almost flags and sticky error flags
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic                    r_en,
  input  logic                    clr_err,
  output logic                    aw,
  output logic                    ar,
  output logic [ADDRESS_SIZE-1:0] w_addr,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    w_full,
  output logic                    r_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    w_overflow,
  output logic                    r_underflow
);
  localparam int PW = ptr_w(ADDRESS_SIZE);
  localparam logic [PW-1:0] AF = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE = PW'(AE_LEVEL);
  localparam logic [PW-1:0] WRAP = {1'b1, {ADDRESS_SIZE{1'b0}}};
  logic [PW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic w_overflow_q, w_overflow_d, r_underflow_q, r_underflow_d;
  // flags decode straight from the registered pointers; full is judged before any same-cycle read
  always_comb begin
    count = w_ptr_q - r_ptr_q;
    w_full = (w_ptr_q ^ r_ptr_q) == WRAP;
    r_empty = w_ptr_q == r_ptr_q;
    almost_full = count >= AF;
    almost_empty = count <= AE;
    aw = w_en & ~w_full;
    ar = r_en & ~r_empty;
    w_addr = w_ptr_q[ADDRESS_SIZE-1:0];
    r_addr = r_ptr_q[ADDRESS_SIZE-1:0];
    w_ptr_d = w_ptr_q + PW'(aw);
    r_ptr_d = r_ptr_q + PW'(ar);
    w_overflow_d = (w_en & w_full) | (w_overflow_q & ~clr_err);
    r_underflow_d = (r_en & r_empty) | (r_underflow_q & ~clr_err);
  end
  // pointer and sticky error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      w_overflow_q <= 1'b0;
      r_underflow_q <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      w_overflow_q <= w_overflow_d;
      r_underflow_q <= r_underflow_d;
    end
  end
  assign w_overflow = w_overflow_q;
  assign r_underflow = r_underflow_q;
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with fill level, thresholds, FWFT option and error flags
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int MEMORY_WIDTH = 8,
  parameter int ADDRESS_SIZE = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1,
  parameter int FWFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [MEMORY_WIDTH-1:0] wdata,
  input  logic                    r_en,
  input  logic                    clr_err,
  output logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    w_full,
  output logic                    r_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    w_overflow,
  output logic                    r_underflow
);
  localparam int MEMORY_DEPTH = 1 << ADDRESS_SIZE;
  logic aw, ar;
  logic [ADDRESS_SIZE-1:0] w_addr, r_addr;
  logic [MEMORY_WIDTH-1:0] mem_q [MEMORY_DEPTH];
  fifo_sync_ctrl #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL)
  ) u_ctrl (
    .clk(clk),
    .rst(rst),
    .w_en(w_en),
    .r_en(r_en),
    .clr_err(clr_err),
    .aw(aw),
    .ar(ar),
    .w_addr(w_addr),
    .r_addr(r_addr),
    .count(count),
    .w_full(w_full),
    .r_empty(r_empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .w_overflow(w_overflow),
    .r_underflow(r_underflow)
  );
  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (aw) mem_q[w_addr] <= wdata;
  end
  if (FWFT == int'(FWFT_ON)) begin : g_fwft
    // head word shown directly; forced to zero while empty so reset and idle output are clean
    always_comb rdata = r_empty ? '0 : mem_q[r_addr];
  end else begin : g_std
    logic [MEMORY_WIDTH-1:0] rdata_q, rdata_d;
    // capture head word on an accepted read, otherwise hold
    always_comb rdata_d = ar ? mem_q[r_addr] : rdata_q;
    // registered read data
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else rdata_q <= rdata_d;
    end
    assign rdata = rdata_q;
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: queue-model bench driving a standard and an FWFT instance in lockstep
module tb_fifo_sync_param;
  logic clk = 0, rst = 1, w_en = 0, r_en = 0, clr_err = 0;
  logic [7:0] wdata = 0;
  logic [7:0] s_rdata, f_rdata;
  logic s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_count, f_count;
  logic [7:0] q[$];
  logic mdl_ovf = 0, mdl_unf = 0;
  logic [7:0] mdl_rd = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.MEMORY_WIDTH(8), .ADDRESS_SIZE(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en), .clr_err(clr_err),
    .rdata(s_rdata), .w_full(s_full), .r_empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .w_overflow(s_ovf), .r_underflow(s_unf));

  fifo_sync_param #(.MEMORY_WIDTH(8), .ADDRESS_SIZE(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en), .clr_err(clr_err),
    .rdata(f_rdata), .w_full(f_full), .r_empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .w_overflow(f_ovf), .r_underflow(f_unf));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdl_ovf = 0;
    mdl_unf = 0;
    mdl_rd = 0;
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit full, empty;
    w_en = w; wdata = d; r_en = r; clr_err = c;
    @(posedge clk);
    full = q.size() == 8;
    empty = q.size() == 0;
    mdl_ovf = (w && full) || (mdl_ovf && !c);
    mdl_unf = (r && empty) || (mdl_unf && !c);
    if (r && !empty) mdl_rd = q.pop_front();
    if (w && !full) q.push_back(d);
    #1;
    w_en = 0; r_en = 0; clr_err = 0;
  endtask

  always @(negedge clk) begin
    chk("count", s_count, q.size());
    chk("f_count", f_count, q.size());
    chk("w_full", s_full, q.size() == 8);
    chk("f_w_full", f_full, q.size() == 8);
    chk("r_empty", s_empty, q.size() == 0);
    chk("f_r_empty", f_empty, q.size() == 0);
    chk("almost_full", s_af, q.size() >= 6);
    chk("almost_empty", s_ae, q.size() <= 1);
    chk("f_almost", {f_af, f_ae}, {q.size() >= 6, q.size() <= 1});
    chk("w_overflow", {s_ovf, f_ovf}, {mdl_ovf, mdl_ovf});
    chk("r_underflow", {s_unf, f_unf}, {mdl_unf, mdl_unf});
    chk("rdata_std", s_rdata, mdl_rd);
    if (q.size() != 0) chk("rdata_fwft", f_rdata, q[0]);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_count", s_count, 0);
    chk("rst_flags", {s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, 6'b110000);
    chk("rst_rdata", s_rdata, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0, 0);
      chk("fill_count", s_count, i);
      chk("fill_af", s_af, i >= 6);
    end
    chk("fill_full", s_full, 1);
    step(1, 8'hFF, 0, 0);
    chk("ovf_set", s_ovf, 1);
    chk("ovf_count", s_count, 8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 0);
      chk("drain_rdata", s_rdata, i);
    end
    chk("drain_empty", s_empty, 1);
    step(0, 0, 1, 0);
    chk("unf_set", s_unf, 1);
    step(0, 0, 0, 1);
    chk("clr_err", {s_ovf, s_unf, f_ovf, f_unf}, 4'b0000);
    step(1, 8'hA5, 0, 0);
    chk("fwft_empty", f_empty, 0);
    chk("fwft_rdata", f_rdata, 8'hA5);
    step(0, 0, 0, 0);
    chk("fwft_hold", f_rdata, 8'hA5);
    step(0, 0, 1, 0);
    chk("fwft_pop", f_empty, 1);
    chk("std_after_pop", s_rdata, 8'hA5);
    for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'h20 + 8'(i), 1, 0);
      chk("wrap_count", s_count, 4);
    end
    chk("wrap_last", s_rdata, 8'h2F);
    chk("wrap_head", f_rdata, 8'h30);
    for (int i = 0; i < 4; i++) step(1, 8'h40 + 8'(i), 0, 0);
    chk("refill_full", s_full, 1);
    step(1, 8'h99, 1, 0);
    chk("full_rw_count", s_count, 7);
    chk("full_rw_ovf", s_ovf, 1);
    chk("full_rw_rdata", s_rdata, 8'h30);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("pre_rst_count", s_count, 5);
    w_en = 1; wdata = 8'h50;
    #2 rst = 1;
    model_reset();
    #1;
    chk("async_count", {s_count, f_count}, 8'h00);
    chk("async_flags", {s_empty, s_ae, s_full, s_af, s_ovf, s_unf}, 6'b110000);
    chk("async_rdata", s_rdata, 8'h00);
    w_en = 0;
    @(posedge clk);
    #1 rst = 0;
    step(1, 8'h3C, 0, 0);
    chk("post_rst_fwft", f_rdata, 8'h3C);
    step(0, 0, 1, 0);
    chk("post_rst_std", s_rdata, 8'h3C);
    step(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
